// File: rtl/data_sync_tx.sv
// data_sync_tx: source side of a level-qualified bus handshake for crossing
// into another clock domain. Each accepted word is held on unsync_bus while
// bus_enable stays high for HOLD_CYCLES cycles. bus_enable then stays low for
// at least GAP_CYCLES cycles, so the receiver's synchronizer sees clean levels.
module data_sync_tx #(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] unsync_bus,
    output logic             bus_enable,
    output logic             busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ASSERT = 2'd1;
    localparam logic [1:0] GAP    = 2'd2;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

    logic [1:0]       state;
    logic [7:0]       cnt;
    logic             pend_valid;
    logic [WIDTH-1:0] pend_data;
    logic             load;
    logic             accept;

    // A pending word is launched from IDLE, or straight out of the last GAP cycle.
    assign load   = pend_valid && ((state == IDLE) || ((state == GAP) && (cnt == 8'd0)));
    assign accept = in_valid && !pend_valid;

    // in_ready depends only on a register, so it has no path from in_valid.
    assign in_ready = !pend_valid;
    assign busy     = (state != IDLE);

    // One-entry pending buffer. A load and an accept never happen on the
    // same edge: a load needs pend_valid=1 and an accept needs pend_valid=0.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pend_valid <= 1'b0;
            pend_data  <= '0;
        end else if (load) begin
            pend_valid <= 1'b0;
        end else if (accept) begin
            pend_valid <= 1'b1;
            pend_data  <= in_data;
        end
    end

    // Hold/gap sequencer that drives the registered bus and its qualifier.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            cnt        <= '0;
            unsync_bus <= '0;
            bus_enable <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        unsync_bus <= pend_data;
                        bus_enable <= 1'b1;
                        cnt        <= HOLD_LOAD;
                        state      <= ASSERT;
                    end
                end
                ASSERT: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        bus_enable <= 1'b0;
                        cnt        <= GAP_LOAD;
                        state      <= GAP;
                    end
                end
                GAP: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else if (load) begin
                        unsync_bus <= pend_data;
                        bus_enable <= 1'b1;
                        cnt        <= HOLD_LOAD;
                        state      <= ASSERT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    bus_enable <= 1'b0;
                    cnt        <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_sync_tx.sv
// Bench for data_sync_tx. A timeline model of the bench predicts every output
// on every cycle: a word launches once a slot is free, that is at least
// HOLD+GAP edges after the previous launch. Directed sequences with literal
// expectations pin down the model.
module tb_data_sync_tx;

    localparam int W = 8;
    localparam int H = 3;
    localparam int G = 2;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic [W-1:0] unsync_bus;
    logic         bus_enable;
    logic         busy;

    data_sync_tx #(.WIDTH(W), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .unsync_bus (unsync_bus),
        .bus_enable (bus_enable),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: edge index, edge of the last launch, and a one-word pending slot.
    int e = 0;
    int load_t = -1000;
    bit pend_v = 1'b0;
    int pend_d = 0;
    int bus_m = 0;
    int exp_en = 0, exp_busy = 0, exp_rdy = 1, exp_bus = 0;

    always @(posedge CLK) begin
        bit ld, acc;
        e++;
        if (!RST) begin
            pend_v = 1'b0;
            bus_m  = 0;
            load_t = e - 1000;
        end else begin
            ld  = pend_v && (e >= load_t + H + G);
            acc = in_valid && !pend_v;
            if (ld) begin
                bus_m  = pend_d;
                load_t = e;
                pend_v = 1'b0;
            end
            if (acc) begin
                pend_v = 1'b1;
                pend_d = int'(in_data);
            end
        end
        exp_en   = (e - load_t < H) ? 1 : 0;
        exp_busy = (e - load_t < H + G) ? 1 : 0;
        exp_rdy  = pend_v ? 0 : 1;
        exp_bus  = bus_m;
    end

    // Per-cycle compare against the model, plus rising-edge count of bus_enable.
    int rises = 0;
    bit prev_en = 1'b0;
    always @(negedge CLK) begin
        if (!RST) begin
            chk("rst_bus", int'(unsync_bus), 0);
            chk("rst_en", int'(bus_enable), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_ready", int'(in_ready), 1);
            prev_en = 1'b0;
        end else begin
            chk("bus", int'(unsync_bus), exp_bus);
            chk("en", int'(bus_enable), exp_en);
            chk("busy", int'(busy), exp_busy);
            chk("ready", int'(in_ready), exp_rdy);
            if (bus_enable && !prev_en) rises++;
            prev_en = bus_enable;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    // Offer one word and hold it until an edge where in_ready was high takes it.
    task automatic send(input logic [W-1:0] d);
        bit rdy;
        int n;
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        do begin
            @(negedge CLK);
            rdy = in_ready;
            @(posedge CLK);
            #2;
            n++;
        end while (!rdy && n < 50);
        if (!rdy) chk("send_timeout", 0, 1);
    endtask

    // Single word from IDLE: enable after edges 1..3, busy through edge 5.
    task automatic word_literal(input logic [W-1:0] d, input string name);
        logic [6:0] en_v, busy_v;
        en_v = '0;
        busy_v = '0;
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        chk({name, "_ready_after_accept"}, int'(in_ready), 0);
        for (int i = 1; i <= 7; i++) begin
            tick();
            en_v   = {en_v[5:0], bus_enable};
            busy_v = {busy_v[5:0], busy};
            chk({name, "_bus_held"}, int'(unsync_bus), int'(d));
        end
        chk({name, "_en_pattern"}, int'(en_v), int'(7'b1110000));
        chk({name, "_busy_pattern"}, int'(busy_v), int'(7'b1111100));
    endtask

    initial begin
        logic [7:0] en_v;
        int r0;

        // Reset held with a word on offer: nothing may be accepted.
        RST = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hFF;
        repeat (3) tick();
        chk("reset_hold_ready", int'(in_ready), 1);
        chk("reset_hold_bus", int'(unsync_bus), 0);
        in_valid = 1'b0;
        RST = 1'b1;
        tick();
        chk("post_reset_idle_busy", int'(busy), 0);
        chk("post_reset_idle_en", int'(bus_enable), 0);

        word_literal(8'hA5, "single");

        // Back-to-back: 0x22 waits one edge behind the launch of 0x11.
        en_v = '0;
        in_valid = 1'b1;
        in_data = 8'h11;
        tick();
        in_data = 8'h22;
        chk("b2b_ready_e0", int'(in_ready), 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 1) chk("b2b_ready_e1", int'(in_ready), 1);
            if (i == 2) begin
                in_valid = 1'b0;
                chk("b2b_ready_e2", int'(in_ready), 0);
            end
            en_v = {en_v[6:0], bus_enable};
            if (i == 5) chk("b2b_bus_e5", int'(unsync_bus), 8'h11);
            if (i == 6) chk("b2b_bus_e6", int'(unsync_bus), 8'h22);
        end
        chk("b2b_en_pattern", int'(en_v), int'(8'b11100111));
        repeat (6) tick();

        // Backpressure: three words offered continuously.
        r0 = rises;
        send(8'h01);
        send(8'h02);
        send(8'h03);
        in_valid = 1'b0;
        repeat (20) tick();
        chk("bp_rises", rises - r0, 3);
        chk("bp_last_word", int'(unsync_bus), 8'h03);

        // Reset during the second ASSERT cycle of 0x5A while 0x6B is pending.
        send(8'h5A);
        send(8'h6B);
        in_valid = 1'b0;
        chk("mid_en_before_reset", int'(bus_enable), 1);
        RST = 1'b0;
        #1;
        chk("mid_rst_bus", int'(unsync_bus), 0);
        chk("mid_rst_en", int'(bus_enable), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ready", int'(in_ready), 1);
        tick();
        RST = 1'b1;
        tick();
        chk("mid_no_6b", int'(bus_enable), 0);
        word_literal(8'h7C, "post_reset");

        // Randomized traffic with occasional resets, checked by the model.
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 99) < 60);
            in_data  = 8'($urandom);
            if ($urandom_range(0, 99) == 0) RST = 1'b0;
            else RST = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        RST = 1'b1;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
